// File: rtl/mem_access_responder_pkg.sv
// Shared types and constants for the memory access responder and its byte-masked store.
package mem_access_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  localparam int CNT_W = 4;

  // Brings the addressed byte lane down to bit 0, zero-filling the top.
  function automatic logic [31:0] lane_align_right(input logic [31:0] word,
                                                   input logic [1:0]  offset);
    return word >> {offset, 3'b000};
  endfunction

endpackage

// File: rtl/sp_ram_bytemask.sv
// Single-port word store with per-byte write enables; the read port shows write-merged data.
module sp_ram_bytemask #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // A read in the same cycle as a write observes the bytes being written.
  always_comb begin
    rdata = mem[addr];
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        rdata[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_access_responder.sv
// Target-side responder for a level-held request / Valid-pulse memory handshake,
// with right-justified lane alignment onto a word-organised store.
module mem_access_responder
  import mem_access_responder_pkg::*;
#(
  parameter int memAddrWidth = 16,
  parameter int LATENCY      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    Mem_R,
  input  logic [3:0]              Mem_W,
  input  logic [memAddrWidth-1:0] Addr,
  input  logic [31:0]             WData,
  output logic [31:0]             RData,
  output logic                    Valid
);

  localparam int IDX_W = memAddrWidth - 2;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             commit;

  logic [IDX_W-1:0] idx_q;
  logic [1:0]       off_q;
  logic             wr_q;
  logic [3:0]       mask_q;
  logic [31:0]      data_q;
  logic [31:0]      rdata_q;

  logic             req;
  logic             live_wr;
  logic [3:0]       live_mask;
  logic [31:0]      live_data;
  logic             use_live;

  logic [IDX_W-1:0] ram_idx;
  logic [1:0]       ram_off;
  logic             ram_wr;
  logic [3:0]       ram_we;
  logic [31:0]      ram_wdata;
  logic [31:0]      ram_rdata;

  assign live_wr   = |Mem_W;
  assign req       = Mem_R | live_wr;
  assign live_mask = Mem_W << Addr[1:0];
  assign live_data = WData << {Addr[1:0], 3'b000};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_nxt = S_RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_nxt = S_RESP;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // With single-cycle latency the commit edge is also the acceptance edge,
  // so the store must see the live request rather than the latched copy.
  always_comb begin
    use_live  = (state == S_IDLE);
    ram_idx   = use_live ? Addr[memAddrWidth-1:2] : idx_q;
    ram_off   = use_live ? Addr[1:0] : off_q;
    ram_wr    = use_live ? live_wr : wr_q;
    ram_wdata = use_live ? live_data : data_q;
    ram_we    = (commit && ram_wr) ? (use_live ? live_mask : mask_q) : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      wr_q    <= 1'b0;
      mask_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == S_IDLE && req) begin
        idx_q  <= Addr[memAddrWidth-1:2];
        off_q  <= Addr[1:0];
        wr_q   <= live_wr;
        mask_q <= live_mask;
        data_q <= live_data;
      end
      if (commit && !ram_wr) begin
        rdata_q <= lane_align_right(ram_rdata, ram_off);
      end
    end
  end

  sp_ram_bytemask #(
    .ADDR_W (IDX_W),
    .DEPTH  (2 ** IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign Valid = (state == S_RESP);
  assign RData = rdata_q;

endmodule

// File: doc/mem_access_responder.md
Name: mem_access_responder

Overview:
- Target-side responder for the pipeline's memory request/valid handshake.
- One instance serves the instruction port (IM_Mem_R / IM_Mem_W / IM_Valid) and a second serves the data port (DM_Mem_R / DM_Mem_W / DM_Valid).
- Accepts level-held read or byte-masked write requests and completes each after a configurable latency with a one-cycle Valid pulse.
- Holds a word-organised backing store and performs lane alignment, so the requester supplies a right-justified mask and right-justified data.

Parameters:
memAddrWidth, 16, byte address width; the store holds 2^(memAddrWidth-2) 32-bit words
LATENCY, 2, cycles from request acceptance to Valid; legal range 1..15

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
Mem_R  input  1  read request, level-held by the requester until Valid is seen
Mem_W  input  4  write byte mask, right-justified (0001 byte, 0011 half, 1111 word); 0000 means no write
Addr  input  memAddrWidth  byte address
WData  input  32  write data, right-justified
RData  output  32  read data, right-justified (shifted right by 8*Addr[1:0]); no sign extension
Valid  output  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, Valid=0, RData=0, counter=0.
  - Store contents are not cleared.
  - Reset during WAIT aborts the access: no write is committed and no Valid is issued.
- Request: req = Mem_R | (Mem_W != 0).
  - If both are asserted, the write takes priority and no read data is updated.
- States: IDLE, WAIT, RESP.
  - IDLE, req=1 at an edge:
    - Latch word index = Addr[memAddrWidth-1:2], offset = Addr[1:0], op, mask and data.
    - Shifted mask = Mem_W << offset, truncated to 4 bits.
    - Shifted data = WData << (8*offset), truncated to 32 bits.
    - Lanes pushed beyond bit 31 by a misaligned half or word are discarded, and no trap is raised.
    - If LATENCY=1, go to RESP; otherwise go to WAIT with counter=LATENCY-2.
  - IDLE, req=0: stay in IDLE.
  - WAIT: if counter=0, go to RESP; otherwise decrement the counter.
  - RESP: Valid=1 for exactly this cycle, then go to IDLE unconditionally.
- Commit point: the edge that enters RESP.
  - Write: byte lanes with shifted-mask=1 are updated; the other lanes are untouched.
  - Read: RData <= stored word >> (8*offset), zero-filled above.
  - RData stays stable until the next read commit. Writes leave RData unchanged.
- Timing: request first sampled in IDLE at the edge ending cycle t; Valid is high in cycle t+LATENCY.
  - The requester samples Valid combinationally in that cycle.
- Request still asserted in the cycle after RESP: treated as a new access, with Addr re-sampled.
  - The requester relies on this for back-to-back fetches.
  - Throughput is one access per LATENCY+1 cycles.
- Inputs ignored while in WAIT or RESP.
  - A request dropped mid-access still completes and pulses Valid.
  - Addr/WData changes after acceptance have no effect.
- A read issued right after a write to the same word returns the written bytes; there is no stale read.
- Address wrap: the word index is naturally modulo the store depth; out-of-range addresses do not exist.

Decomposition:
- Shared package holds:
  - state encoding constants S_IDLE=2'd0, S_WAIT=2'd1, S_RESP=2'd2;
  - byte-mask constants MASK_B=4'b0001, MASK_H=4'b0011, MASK_W=4'b1111;
  - counter width 4.
- One sub-module, sp_ram_bytemask:
  - single port, 32-bit word, 4-bit byte write enable;
  - write and read at the same edge, with read returning write-merged data;
  - depth parameter 2^(memAddrWidth-2).
- The responder owns the FSM, latching and lane shifting.

Test Plan:
1. Reset then idle, LATENCY=2: hold rst 3 cycles, release, no req for 5 cycles -> Valid=0 and RData=0 throughout.
2. Word write then read, LATENCY=2:
   - Mem_W=1111, Addr=0x0010, WData=0xDEADBEEF held from cycle 0 -> Valid only in cycle 2.
   - Drop req, then Mem_R at 0x0010 -> Valid two cycles after acceptance, RData=0xDEADBEEF.
3. Byte/half lanes:
   - After test 2, write Mem_W=0001 Addr=0x0012 WData=0x000000AA -> word=0xDEAABEEF.
   - Read Addr=0x0012 -> RData=0x0000DEAA.
   - Write Mem_W=0011 Addr=0x0010 WData=0x1234 -> read Addr=0x0010 returns 0xDEAA1234.
4. Back-to-back, LATENCY=1: Mem_R held high for 8 cycles with Addr advancing 0,4,8 on each Valid -> Valid in cycles 1,3,5,7 with the matching words.
5. Reset mid-access, LATENCY=3: Mem_W=1111 Addr=0x0020 WData=0x55555555 accepted, rst pulsed in WAIT -> no Valid, and a later read of 0x0020 returns the prior contents.
6. Request withdrawn: Mem_R asserted for only the acceptance cycle -> Valid still pulses once at t+LATENCY, with no second access.
